// File: rtl/fetch_ctrl_if.sv
// Bus between the instruction-fetch controller and the rest of the core:
// decoded control inputs plus the fetch address and status outputs.
interface fetch_ctrl_if;
  logic        start;
  logic        halt;
  logic        stall;
  logic        jumpFlag;
  logic [7:0]  jumpOffset;
  logic [9:0]  pc;
  logic        fetchEn;
  logic        squash;
  logic        done;
  logic [15:0] cycleCount;

  modport master (
    output start, halt, stall, jumpFlag, jumpOffset,
    input  pc, fetchEn, squash, done, cycleCount
  );

  modport slave (
    input  start, halt, stall, jumpFlag, jumpOffset,
    output pc, fetchEn, squash, done, cycleCount
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: sequences the program counter through
// run, taken-jump bubble and halt, and counts executed cycles.
module fetch_ctrl (
  input  logic         clk,
  input  logic         reset,
  fetch_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [9:0]  r_pc;
  logic [9:0]  w_nextPc;
  logic [9:0]  w_jumpTarget;
  logic        w_clearCount;
  logic [15:0] r_cycleCount;

  // 10-bit addition wraps modulo 1024 for free
  assign w_jumpTarget = r_pc + {{2{bus.jumpOffset[7]}}, bus.jumpOffset};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_pc    <= 10'd0;
    end else begin
      r_state <= w_nextState;
      r_pc    <= w_nextPc;
    end
  end

  always_comb begin
    w_nextState  = r_state;
    w_nextPc     = r_pc;
    w_clearCount = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (bus.start) begin
          w_nextState  = RUN;
          w_nextPc     = 10'd0;
          w_clearCount = 1'b1;
        end
      end
      RUN: begin
        if (bus.halt) begin
          w_nextState = DONE;
        end else if (bus.jumpFlag) begin
          w_nextState = REDIRECT;
          w_nextPc    = w_jumpTarget;
        end else if (!bus.stall) begin
          w_nextPc = r_pc + 10'd1;
        end
      end
      REDIRECT: begin
        w_nextState = RUN;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Counts cycles spent in RUN or REDIRECT; restarts on every program launch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cycleCount <= 16'd0;
    end else if (w_clearCount) begin
      r_cycleCount <= 16'd0;
    end else if ((r_state == RUN || r_state == REDIRECT) && r_cycleCount != 16'hFFFF) begin
      r_cycleCount <= r_cycleCount + 16'd1;
    end
  end

  assign bus.pc         = r_pc;
  assign bus.fetchEn    = (r_state == RUN);
  assign bus.squash     = (r_state == REDIRECT);
  assign bus.done       = (r_state == DONE);
  assign bus.cycleCount = r_cycleCount;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus random
// control traffic compared against a behavioural program-counter model.
module tb_fetch_ctrl;

  logic clk;
  logic reset;
  fetch_ctrl_if bus ();

  fetch_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectorCount = 0;
  int missCount   = 0;

  // Reference model: phase names, an integer address and an integer count
  localparam int PH_IDLE   = 0;
  localparam int PH_RUN    = 1;
  localparam int PH_BUBBLE = 2;
  localparam int PH_DONE   = 3;
  int mPhase;
  int mPc;
  int mCount;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".pc"}, int'(bus.pc), mPc);
    checkOutput({tag, ".fetchEn"}, int'(bus.fetchEn), int'(mPhase == PH_RUN));
    checkOutput({tag, ".squash"}, int'(bus.squash), int'(mPhase == PH_BUBBLE));
    checkOutput({tag, ".done"}, int'(bus.done), int'(mPhase == PH_DONE));
    checkOutput({tag, ".cycleCount"}, int'(bus.cycleCount), mCount);
  endtask

  function automatic void modelReset();
    mPhase = PH_IDLE;
    mPc    = 0;
    mCount = 0;
  endfunction

  function automatic void modelEdge(input bit st, input bit h, input bit j, input bit s, input int off);
    int signedOff;
    signedOff = (off >= 128) ? off - 256 : off;
    if (mPhase == PH_RUN || mPhase == PH_BUBBLE)
      mCount = (mCount < 65535) ? mCount + 1 : 65535;
    if (mPhase == PH_IDLE || mPhase == PH_DONE) begin
      if (st) begin
        mPhase = PH_RUN;
        mPc    = 0;
        mCount = 0;
      end
    end else if (mPhase == PH_BUBBLE) begin
      mPhase = PH_RUN;
    end else if (h) begin
      mPhase = PH_DONE;
    end else if (j) begin
      mPc    = (mPc + signedOff + 1024) % 1024;
      mPhase = PH_BUBBLE;
    end else if (!s) begin
      mPc = (mPc + 1) % 1024;
    end
  endfunction

  task automatic applyStimulus(input bit st, input bit h, input bit j, input bit s,
                               input int off, input bit doCheck);
    bus.start      = st;
    bus.halt       = h;
    bus.jumpFlag   = j;
    bus.stall      = s;
    bus.jumpOffset = off[7:0];
    @(posedge clk);
    modelEdge(st, h, j, s, off);
    #1;
    if (doCheck) checkAll("step");
  endtask

  // Asserts reset between edges and checks its effect before any clock edge
  task automatic asyncReset();
    reset = 1'b1;
    #1;
    modelReset();
    checkAll("asyncReset");
    #1;
    reset = 1'b0;
  endtask

  task automatic launch();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1);
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.halt       = 1'b0;
    bus.jumpFlag   = 1'b0;
    bus.stall      = 1'b0;
    bus.jumpOffset = 8'd0;
    reset          = 1'b1;
    modelReset();
    #2;
    checkAll("resetHeld");
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkAll("resetState");

    // Straight-line execution from PC 0
    launch();
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    checkOutput("seq.pc", int'(bus.pc), 5);
    checkOutput("seq.count", int'(bus.cycleCount), 5);

    // Backward jump of -5 from PC 10 and its bubble
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    checkOutput("preJump.pc", int'(bus.pc), 10);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'hFB, 1'b1);
    checkOutput("jump.pc", int'(bus.pc), 5);
    checkOutput("jump.squash", int'(bus.squash), 1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h40, 1'b1);
    checkOutput("bubbleIgnore.pc", int'(bus.pc), 5);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    checkOutput("afterBubble.pc", int'(bus.pc), 6);

    // Forward wrap at 1023 and backward wrap below 0
    asyncReset();
    launch();
    for (int i = 0; i < 1024; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, i >= 1020);
    checkOutput("wrapUp.pc", int'(bus.pc), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'hF0, 1'b1);
    checkOutput("wrapDown.pc", int'(bus.pc), 1010);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h7F, 1'b1);
    checkOutput("maxFwd.pc", int'(bus.pc), (1010 + 127) % 1024);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h80, 1'b1);
    checkOutput("maxBack.pc", int'(bus.pc), (1010 + 127 - 128) % 1024);

    // Halt wins over jump and stall; restart from DONE
    asyncReset();
    launch();
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'h05, 1'b1);
    checkOutput("halt.pc", int'(bus.pc), 20);
    checkOutput("halt.done", int'(bus.done), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    checkOutput("doneHold.count", int'(bus.cycleCount), 21);
    launch();
    checkOutput("restart.count", int'(bus.cycleCount), 0);

    // Stall holds PC but still counts; reset mid-stall
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1);
    checkOutput("stall.pc", int'(bus.pc), 7);
    checkOutput("stall.count", int'(bus.cycleCount), 10);
    bus.stall = 1'b1;
    asyncReset();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1);

    // Counter saturation after a long stall
    launch();
    for (int i = 0; i < 65540; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 0, i >= 65530);
    checkOutput("sat.count", int'(bus.cycleCount), 65535);

    // Random control traffic
    asyncReset();
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 199));
      if (r < 2) begin
        asyncReset();
      end else begin
        applyStimulus($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 3,
                      $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 20,
                      int'($urandom_range(0, 255)), 1'b1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The module SHALL have ports: clk  input  1  system clock, all state updates on rising edge.
REQ-002 The module SHALL have ports: reset  input  1  asynchronous, active-high reset.
REQ-003 The module SHALL have ports: start  input  1  level, begins program execution from PC 0.
REQ-004 The module SHALL have ports: halt  input  1  decoded halt instruction in the current fetch slot.
REQ-005 The module SHALL have ports: stall  input  1  hold PC this cycle (multi-cycle memory op).
REQ-006 The module SHALL have ports: jumpFlag  input  1  ALU branch-taken flag (BLQZ result).
REQ-007 The module SHALL have ports: jumpOffset  input  8  ALU out, signed two's-complement PC offset.
REQ-008 The module SHALL have ports: pc  output  10  instruction memory address.
REQ-009 The module SHALL have ports: fetchEn  output  1  high when the instruction at pc is valid to execute.
REQ-010 The module SHALL have ports: squash  output  1  high for the one bubble cycle after a taken jump.
REQ-011 The module SHALL have ports: done  output  1  program finished.
REQ-012 The module SHALL have ports: cycleCount  output  16  executed-cycle counter, saturating.

Function
REQ-013 The module SHALL implement the states IDLE, RUN, REDIRECT, DONE in a 2-bit state register.
REQ-014 fetchEn SHALL be 1 only in RUN; squash SHALL be 1 only in REDIRECT; done SHALL be 1 only in DONE (all decoded from state, no input paths).
REQ-015 IDLE: pc = 0; start=1 -> RUN next edge with pc=0 and cycleCount=0.
REQ-016 RUN priority SHALL be halt > jumpFlag > stall > increment, evaluated each rising edge.
REQ-017 RUN, halt=1: next state DONE, pc holds.
REQ-018 RUN, jumpFlag=1 (halt=0): pc <= (pc + sign-extend(jumpOffset) to 10 bits) mod 1024; next state REDIRECT.
REQ-019 RUN, stall=1 (halt=0, jumpFlag=0): pc holds, state stays RUN.
REQ-020 RUN, otherwise: pc <= pc + 1 mod 1024 (1023 wraps to 0), state stays RUN.
REQ-021 REDIRECT SHALL last exactly one cycle: pc holds, halt/jumpFlag/stall/start ignored, next state RUN.
REQ-022 DONE: pc holds; start=1 -> RUN next edge with pc=0, cycleCount=0; start=0 -> stay DONE.
REQ-023 start SHALL be ignored in RUN and REDIRECT.
REQ-024 cycleCount SHALL increment by 1 on every edge where the current state is RUN or REDIRECT, saturating at 0xFFFF; it holds in IDLE and DONE.
REQ-025 Jump offset arithmetic: 0x80 = -128, 0x7F = +127; target below 0 or above 1023 wraps mod 1024.

Reset
REQ-026 reset=1 SHALL immediately (without a clock edge) force state=IDLE, pc=0, cycleCount=0, fetchEn=0, squash=0, done=0.
REQ-027 reset asserted mid-RUN or mid-REDIRECT SHALL discard any pending jump; after deassertion the block waits in IDLE for start.

Verification
REQ-028 Reset, start=1 one cycle, no other inputs, 5 edges -> pc sequence 0,1,2,3,4,5; fetchEn=1; cycleCount=5.
REQ-029 pc=10, jumpFlag=1, jumpOffset=0xFB -> next pc=5, squash=1 and fetchEn=0 for one cycle, then pc=6 with fetchEn=1.
REQ-030 pc=1023 no stall -> pc=0; pc=2 with jumpOffset=0xF0 (-16) taken -> pc=1010.
REQ-031 halt=1, jumpFlag=1, stall=1 same cycle at pc=20 -> DONE, pc=20, done=1, fetchEn=0; later start=1 -> pc=0, cycleCount=0, RUN.
REQ-032 stall=1 for 3 cycles at pc=7 -> pc stays 7, cycleCount still increments by 3; reset asserted mid-stall between edges -> pc=0, state IDLE before next edge.
REQ-033 Force cycleCount to 0xFFFE, run 3 cycles -> 0xFFFF held.
